// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI memory arbiter: FSM encoding, requester IDs
// and the round-robin grant helper.
package spi_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Under contention the requester not granted last wins; a lone request always wins.
  function automatic logic rr_pick(input logic if_req, input logic d_req, input logic last_grant);
    if (if_req && d_req)
      return ~last_grant;
    return d_req ? REQ_D : REQ_IF;
  endfunction

endpackage

// File: rtl/spi_arb_timeout.sv
// WAIT-state cycle counter: cleared outside WAIT, flags expiry once it has
// counted TIMEOUT_CYCLES-1 cycles.
module spi_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count_reg <= '0;
    else if (enable && !expired)
      count_reg <= count_reg + 8'd1;
  end

  assign expired = (count_reg == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI byte-read engine between an
// instruction-fetch port and a data-load port, with a WAIT timeout.
module spi_mem_arbiter
  import spi_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_rvalid,
  output logic [7:0]        rdata,
  output logic              rerr,
  output logic              owner,
  output logic              spi_start,
  output logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [7:0]        spi_data
);

  logic [1:0] state_reg;
  logic       last_grant_reg;
  logic       grant;
  logic       expired;

  assign grant = rr_pick(if_req, d_req, last_grant_reg);

  spi_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg != ST_WAIT),
    .enable  (state_reg == ST_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= REQ_D;
      spi_start      <= 1'b0;
      if_rvalid      <= 1'b0;
      d_rvalid       <= 1'b0;
      rdata          <= 8'h00;
      rerr           <= 1'b0;
      owner          <= REQ_IF;
      spi_addr       <= '0;
    end else begin
      spi_start <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (if_req || d_req) begin
            owner     <= grant;
            spi_addr  <= (grant == REQ_D) ? d_addr : if_addr;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!spi_busy) begin
            spi_start <= 1'b1;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done pulse arriving on the expiry cycle still counts as success.
          if (spi_done || expired) begin
            rdata     <= spi_done ? spi_data : 8'h00;
            rerr      <= !spi_done;
            if_rvalid <= (owner == REQ_IF);
            d_rvalid  <= (owner == REQ_D);
            state_reg <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant_reg <= owner;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed self-checking bench for spi_mem_arbiter; the byte-read engine is
// played by the stimulus sequence itself.
module tb_spi_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int T      = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_rvalid;
  logic              d_req = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic              d_rvalid;
  logic [7:0]        rdata;
  logic              rerr;
  logic              owner;
  logic              spi_start;
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_busy = 1'b0;
  logic              spi_done = 1'b0;
  logic [7:0]        spi_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int if_cnt = 0;
  int d_cnt = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rvalid (if_rvalid),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_rvalid  (d_rvalid),
    .rdata     (rdata),
    .rerr      (rerr),
    .owner     (owner),
    .spi_start (spi_start),
    .spi_addr  (spi_addr),
    .spi_busy  (spi_busy),
    .spi_done  (spi_done),
    .spi_data  (spi_data)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (if_rvalid === 1'b1) if_cnt <= if_cnt + 1;
    if (d_rvalid === 1'b1) d_cnt <= d_cnt + 1;
    if (spi_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max_cycles);
    int n = 0;
    while (spi_start !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("start_seen", {31'd0, spi_start}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    spi_done = 1'b0;
    spi_busy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    int base_if, base_d, base_st, n;
    logic exp_owner;

    // Reset state
    do_reset();
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_rerr", {31'd0, rerr}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_spi_start", {31'd0, spi_start}, 32'd0);
    chk("rst_spi_addr", {16'd0, spi_addr}, 32'd0);
    $display("txn reset: done");

    // Fetch only, engine answers 20 cycles after start
    base_d = d_cnt; base_if = if_cnt; base_st = start_cnt;
    if_req = 1'b1; if_addr = 16'h0003;
    tick();
    chk("fetch_owner", {31'd0, owner}, 32'd0);
    chk("fetch_spi_addr", {16'd0, spi_addr}, 32'h0003);
    chk("fetch_no_start_yet", {31'd0, spi_start}, 32'd0);
    tick();
    chk("fetch_min_latency_start", {31'd0, spi_start}, 32'd1);
    repeat (19) tick();
    chk("fetch_no_early_rvalid", if_cnt - base_if, 32'd0);
    spi_done = 1'b1; spi_data = 8'hA5;
    tick();
    spi_done = 1'b0;
    chk("fetch_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("fetch_rdata", {24'd0, rdata}, 32'hA5);
    chk("fetch_rerr", {31'd0, rerr}, 32'd0);
    if_req = 1'b0;
    repeat (3) tick();
    chk("fetch_if_pulses", if_cnt - base_if, 32'd1);
    chk("fetch_d_never", d_cnt - base_d, 32'd0);
    chk("fetch_start_pulses", start_cnt - base_st, 32'd1);
    $display("txn fetch_only: addr=0003 rdata=%02h rerr=%0d", rdata, rerr);

    // Contention out of reset: IF, D, IF, D, IF, D
    do_reset();
    if_addr = 16'h0010; d_addr = 16'h0020;
    if_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp_owner = logic'(g % 2);
      wait_start(10);
      chk("cont_owner", {31'd0, owner}, {31'd0, exp_owner});
      chk("cont_spi_addr", {16'd0, spi_addr}, exp_owner ? 32'h20 : 32'h10);
      spi_done = 1'b1; spi_data = 8'(8'h10 + g);
      tick();
      spi_done = 1'b0;
      chk("cont_if_rvalid", {31'd0, if_rvalid}, {31'd0, !exp_owner});
      chk("cont_d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_owner});
      chk("cont_rdata", {24'd0, rdata}, 32'(8'h10 + g));
      $display("txn contention grant %0d: owner=%0d rdata=%02h", g, owner, rdata);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();

    // Timeout: engine silent, rvalid exactly T cycles after spi_start
    base_if = if_cnt;
    d_req = 1'b1; d_addr = 16'h0055;
    wait_start(10);
    n = 0;
    while (d_rvalid !== 1'b1 && n < T + 10) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, T);
    chk("timeout_rerr", {31'd0, rerr}, 32'd1);
    chk("timeout_rdata", {24'd0, rdata}, 32'h00);
    d_req = 1'b0;
    repeat (4) tick();
    chk("timeout_no_if", if_cnt - base_if, 32'd0);
    chk("hold_rerr", {31'd0, rerr}, 32'd1);
    chk("hold_rdata", {24'd0, rdata}, 32'h00);
    $display("txn timeout: latency=%0d rerr=%0d rdata=%02h", n, rerr, rdata);

    // spi_done on the expiry cycle wins over timeout
    base_d = d_cnt;
    d_req = 1'b1; d_addr = 16'h0044;
    wait_start(10);
    repeat (T - 1) tick();
    chk("edge_no_early_rvalid", d_cnt - base_d, 32'd0);
    spi_done = 1'b1; spi_data = 8'h3C;
    tick();
    spi_done = 1'b0;
    chk("edge_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("edge_rerr", {31'd0, rerr}, 32'd0);
    chk("edge_rdata", {24'd0, rdata}, 32'h3C);
    d_req = 1'b0;
    repeat (2) tick();
    $display("txn done_at_expiry: rerr=%0d rdata=%02h", rerr, rdata);

    // Busy engine holds ISSUE for 10 cycles
    base_st = start_cnt;
    spi_busy = 1'b1;
    if_req = 1'b1; if_addr = 16'h0007;
    tick();
    repeat (10) tick();
    chk("busy_no_start", start_cnt - base_st, 32'd0);
    chk("busy_start_low", {31'd0, spi_start}, 32'd0);
    spi_busy = 1'b0;
    tick();
    chk("busy_start_after_fall", {31'd0, spi_start}, 32'd1);
    tick();
    chk("busy_start_one_cycle", {31'd0, spi_start}, 32'd0);
    spi_done = 1'b1; spi_data = 8'h77;
    tick();
    spi_done = 1'b0;
    chk("busy_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("busy_rdata", {24'd0, rdata}, 32'h77);
    if_req = 1'b0;
    repeat (3) tick();
    chk("busy_start_pulses", start_cnt - base_st, 32'd1);
    $display("txn busy_engine: starts=%0d rdata=%02h", start_cnt - base_st, rdata);

    // Reset in the 5th WAIT cycle, then a stray spi_done in IDLE
    d_req = 1'b1; d_addr = 16'h0009;
    wait_start(10);
    repeat (4) tick();
    base_if = if_cnt; base_d = d_cnt; base_st = start_cnt;
    reset = 1'b1; d_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_rdata", {24'd0, rdata}, 32'h00);
    chk("midrst_spi_addr", {16'd0, spi_addr}, 32'd0);
    chk("midrst_owner", {31'd0, owner}, 32'd0);
    spi_done = 1'b1; spi_data = 8'hEE;
    tick();
    spi_done = 1'b0;
    repeat (3) tick();
    chk("midrst_no_if_rvalid", if_cnt - base_if, 32'd0);
    chk("midrst_no_d_rvalid", d_cnt - base_d, 32'd0);
    chk("midrst_no_start", start_cnt - base_st, 32'd0);
    chk("midrst_rdata_after", {24'd0, rdata}, 32'h00);
    chk("midrst_rerr_after", {31'd0, rerr}, 32'd0);
    $display("txn reset_mid_wait: rvalids=%0d rdata=%02h", (if_cnt - base_if) + (d_cnt - base_d), rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
